ir_prefetch_queue: RTL

Parametrised instruction register with an integrated prefetch FIFO, placed between instruction memory read data and the control unit. Fetched words are queued as they arrive. The control unit loads the next instruction into the architectural instruction register on demand. A flush discards prefetched words on branch or jump redirect. The block generalises the plain enable-loaded instruction register to configurable width and depth, with valid/ready flow control and a flush.

---
 rtl/ir_prefetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/ir_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ir_prefetch_queue: instruction register fed by a DEPTH-entry prefetch    |
// | FIFO with valid/ready fetch handshake and redirect flush.                |
// | Option: IR_PREFETCH_BYPASS_EN routes RD straight into IRout when empty.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ir_prefetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         RD,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic                     ir_load,
  input  logic                     flush,
  output logic [WIDTH-1:0]         IRout,
  output logic                     ir_valid,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_ir;
  logic             r_ir_valid;

  logic w_empty;
  logic w_ready;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < c_FULL) && !flush && rst_n;

`ifdef IR_PREFETCH_BYPASS_EN
  assign w_bypass = w_empty && fetch_valid && ir_load && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word goes only to IRout, never into the queue.
  assign w_push = fetch_valid && w_ready && !w_bypass;
  assign w_pop  = ir_load && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= RD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // Flush and empty loads invalidate IRout but keep its last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (flush) begin
      r_ir_valid <= 1'b0;
    end else if (ir_load) begin
      if (w_bypass) begin
        r_ir       <= RD;
        r_ir_valid <= 1'b1;
      end else if (!w_empty) begin
        r_ir       <= r_mem[r_rptr];
        r_ir_valid <= 1'b1;
      end else begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign fetch_ready = w_ready;
  assign q_count     = r_count;
  assign IRout       = r_ir;
  assign ir_valid    = r_ir_valid;

endmodule
`default_nettype wire
